// File: rtl/fifo_write_arbiter.sv
// Shares the single write port of fifo_top among NUM_REQ packet sources.
// Round-robin (optional requester-0 priority) arbitration, drop-on-full accounting, status stamping.
module fifo_write_arbiter #(
  parameter int FIFO_WIDTH = 63,
  parameter int FIFO_DEPTH = 2048,
  parameter int FIFO_BITS  = $clog2(FIFO_DEPTH),
  parameter int NUM_REQ    = 4,
  parameter int DROP_BITS  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [FIFO_BITS:0]             fifo_counter,
  input  logic                           fifo_full,
  input  logic                           fifo_half,
  output logic                           write_n,
  output logic [FIFO_WIDTH-1:0]          data_in,
  input  logic                           priority_en,
  input  logic                           drop_on_full,
  input  logic                           clear_drop,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           overflow,
  output logic [NUM_REQ*DROP_BITS-1:0]   drop_count
);

  localparam int                   ID_W      = $clog2(NUM_REQ);
  localparam logic [FIFO_BITS:0]   LAST_FREE = (FIFO_BITS+1)'(FIFO_DEPTH - 1);
  localparam logic [DROP_BITS-1:0] DROP_MAX  = '1;

  logic                  write_n_q, write_n_d;
  logic [FIFO_WIDTH-1:0] data_in_q, data_in_d;
  logic [ID_W-1:0]       grant_id_q, grant_id_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_BITS-1:0]  drop_cnt_q [NUM_REQ];
  logic [DROP_BITS-1:0]  drop_cnt_d [NUM_REQ];

  logic                  room;
  logic                  win_found;
  logic                  prio_win;
  logic [ID_W-1:0]       win_idx;
  logic [ID_W-1:0]       cand_idx;
  int                    cand;
  logic [NUM_REQ-1:0]    drop_vec;
  logic                  drop_any;
  logic                  accept;

  // An in-flight write is one more occupied slot than fifo_counter shows yet.
  // NOTE: every variable gets a default at the top of each always_comb so no path can infer a latch.
  always_comb begin
    room      = !fifo_full && !(!write_n_q && (fifo_counter >= LAST_FREE));
    win_found = 1'b0;
    prio_win  = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    if (priority_en && req_valid[0]) begin
      win_found = 1'b1;
      prio_win  = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = int'(rr_ptr_q) + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        cand_idx = ID_W'(cand);
        if (!win_found && req_valid[cand_idx]) begin
          win_found = 1'b1;
          win_idx   = cand_idx;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    drop_vec  = '0;
    if (!reset) begin
      if (room) begin
        if (win_found) req_ready[win_idx] = 1'b1;
      end else if (drop_on_full) begin
        req_ready = req_valid;
        drop_vec  = req_valid;
      end
    end
  end

  assign drop_any = |drop_vec;
  assign accept   = !reset && room && win_found;

  always_comb begin
    write_n_d  = !accept;
    data_in_d  = data_in_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    overflow_d = overflow_q;
    if (accept) begin
      data_in_d     = req_data[int'(win_idx)*FIFO_WIDTH +: FIFO_WIDTH];
      data_in_d[61] = fifo_half;
      data_in_d[60] = overflow_q | drop_any;
      grant_id_d    = win_idx;
      if (!prio_win) rr_ptr_d = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
    end
    // A drop in the same cycle as clear_drop wins over the clear.
    if (drop_any)        overflow_d = 1'b1;
    else if (clear_drop) overflow_d = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      drop_cnt_d[i] = clear_drop ? '0 : drop_cnt_q[i];
      if (drop_vec[i] && (drop_cnt_d[i] != DROP_MAX)) drop_cnt_d[i] = drop_cnt_d[i] + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the drop counters are a handful of status flops, not a RAM, so resetting them is cheap and required.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_n_q  <= 1'b1;
      data_in_q  <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) drop_cnt_q[i] <= '0;
    end else begin
      write_n_q  <= write_n_d;
      data_in_q  <= data_in_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < NUM_REQ; i++) drop_cnt_q[i] <= drop_cnt_d[i];
    end
  end

  assign write_n  = write_n_q;
  assign data_in  = data_in_q;
  assign grant_id = grant_id_q;
  assign overflow = overflow_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_drop_out
    assign drop_count[g*DROP_BITS +: DROP_BITS] = drop_cnt_q[g];
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized and directed bench for fifo_write_arbiter against a packet-level reference model.
// A second instance with 4-bit drop counters exercises saturation.
module tb_fifo_write_arbiter;

  localparam int W   = 63;
  localparam int D   = 2048;
  localparam int B   = 11;
  localparam int N   = 4;
  localparam int DB  = 16;
  localparam int DB4 = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*W-1:0]    req_data;
  logic [B:0]        fifo_counter;
  logic              fifo_full, fifo_half;
  logic              priority_en, drop_on_full, clear_drop;

  logic [N-1:0]      req_ready, req_ready4;
  logic              write_n, write_n4;
  logic [W-1:0]      data_in, data_in4;
  logic [1:0]        grant_id, grant_id4;
  logic              overflow, overflow4;
  logic [N*DB-1:0]   drop_count;
  logic [N*DB4-1:0]  drop_count4;

  fifo_write_arbiter #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .NUM_REQ(N), .DROP_BITS(DB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_counter(fifo_counter), .fifo_full(fifo_full), .fifo_half(fifo_half),
    .write_n(write_n), .data_in(data_in), .priority_en(priority_en), .drop_on_full(drop_on_full),
    .clear_drop(clear_drop), .grant_id(grant_id), .overflow(overflow), .drop_count(drop_count));

  fifo_write_arbiter #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .NUM_REQ(N), .DROP_BITS(DB4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready4),
    .fifo_counter(fifo_counter), .fifo_full(fifo_full), .fifo_half(fifo_half),
    .write_n(write_n4), .data_in(data_in4), .priority_en(priority_en), .drop_on_full(drop_on_full),
    .clear_drop(clear_drop), .grant_id(grant_id4), .overflow(overflow4), .drop_count(drop_count4));

  always #5 clk = ~clk;

  int total, bad;

  // Reference model: expected registered outputs and arbitration pointer.
  bit           m_wn;
  logic [W-1:0] m_data;
  int           m_gid, m_rr;
  bit           m_ovf;
  int           m_drop [N];
  int           m_drop4[N];
  logic [N-1:0] exp_ready, seen_ready;

  // FIFO environment: occupancy, writes captured, writes attempted while full.
  int occ, writes, bad_writes;
  logic [W-1:0] rr_data [N];

  function automatic logic [W-1:0] rnd_word();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic model_init();
    m_wn = 1'b1; m_data = '0; m_gid = 0; m_rr = 0; m_ovf = 1'b0;
    for (int i = 0; i < N; i++) begin m_drop[i] = 0; m_drop4[i] = 0; end
  endtask

  task automatic set_fifo();
    fifo_counter = (B+1)'(occ);
    fifo_full    = (occ == D);
    fifo_half    = (occ >= D/2);
  endtask

  // One clock: predict ready from the rules, update the model, advance, emulate fifo_top.
  task automatic step(input bit rd = 1'b0);
    logic [N-1:0] v;
    logic [W-1:0] st;
    bit room, prio, found, dropped, pre_wn;
    int w;
    #1;
    v = req_valid;
    room = !fifo_full && !(!m_wn && int'(fifo_counter) >= D-1);
    prio = 1'b0; found = 1'b0; w = 0;
    if (priority_en && v[0]) begin
      prio = 1'b1; found = 1'b1;
    end else begin
      for (int k = 0; k < N; k++)
        if (!found && v[(m_rr + k) % N]) begin found = 1'b1; w = (m_rr + k) % N; end
    end
    exp_ready = '0;
    if (room) begin
      if (found) exp_ready[w] = 1'b1;
    end else if (drop_on_full) begin
      exp_ready = v;
    end
    seen_ready = req_ready;
    dropped = !room && drop_on_full && (v != '0);
    if (room && found) begin
      st = req_data[w*W +: W];
      st[61] = fifo_half;
      st[60] = m_ovf | dropped;
      m_data = st; m_wn = 1'b0; m_gid = w;
      if (!prio) m_rr = (w + 1) % N;
    end else begin
      m_wn = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (dropped && v[i]) begin
        m_drop[i]  = clear_drop ? 1 : ((m_drop[i]  == 65535) ? 65535 : m_drop[i] + 1);
        m_drop4[i] = clear_drop ? 1 : ((m_drop4[i] == 15)    ? 15    : m_drop4[i] + 1);
      end else if (clear_drop) begin
        m_drop[i] = 0; m_drop4[i] = 0;
      end
    end
    if (dropped) m_ovf = 1'b1;
    else if (clear_drop) m_ovf = 1'b0;
    pre_wn = write_n;
    @(posedge clk);
    if (!pre_wn) begin
      writes++;
      if (occ == D) bad_writes++;
      else occ++;
    end
    if (rd && occ > 0) occ--;
    #1;
    set_fifo();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (write_n !== 1'b1) begin bad++; $display("FAIL reset_write_n got=%b want=1", write_n); end
    total++; if (data_in !== '0) begin bad++; $display("FAIL reset_data_in got=%h want=0", data_in); end
    total++; if (grant_id !== '0) begin bad++; $display("FAIL reset_grant_id got=%0d want=0", grant_id); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    total++; if (drop_count !== '0) begin bad++; $display("FAIL reset_drop_count got=%h want=0", drop_count); end
    total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    @(negedge clk);
    reset = 1'b0;
    req_valid = '0;
    model_init();
  endtask

  task automatic test_round_robin();
    for (int j = 0; j < N; j++) begin
      rr_data[j] = rnd_word() ^ W'(j);
      req_data[j*W +: W] = rr_data[j];
    end
    req_valid = '1;
    for (int i = 0; i < 9; i++) begin
      step();
      total++; if (int'(grant_id) !== i % N) begin bad++; $display("FAIL rr_grant[%0d] got=%0d want=%0d", i, grant_id, i % N); end
      total++; if (write_n !== 1'b0) begin bad++; $display("FAIL rr_write_n[%0d] got=%b want=0", i, write_n); end
      total++; if (data_in[59:0] !== rr_data[i % N][59:0]) begin bad++; $display("FAIL rr_data[%0d] got=%h want=%h", i, data_in[59:0], rr_data[i % N][59:0]); end
      total++; if (data_in !== m_data) begin bad++; $display("FAIL rr_stamp[%0d] got=%h want=%h", i, data_in, m_data); end
      total++; if (seen_ready !== exp_ready) begin bad++; $display("FAIL rr_ready[%0d] got=%b want=%b", i, seen_ready, exp_ready); end
    end
  endtask

  task automatic test_priority();
    priority_en = 1'b1;
    req_valid = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      step();
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL prio_grant[%0d] got=%0d want=0", i, grant_id); end
      total++; if (seen_ready !== 4'b0001) begin bad++; $display("FAIL prio_ready[%0d] got=%b want=0001", i, seen_ready); end
    end
    priority_en = 1'b0;
    step();
    total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL prio_release_grant got=%0d want=2", grant_id); end
    total++; if (data_in[59:0] !== rr_data[2][59:0]) begin bad++; $display("FAIL prio_release_data got=%h want=%h", data_in[59:0], rr_data[2][59:0]); end
  endtask

  task automatic test_fill();
    int  ready_err;
    int  seen_inflight;
    bit  inflight;
    req_valid = '0;
    step();
    occ = 0; writes = 0; bad_writes = 0;
    set_fifo();
    ready_err = 0; seen_inflight = 0;
    req_valid = '1;
    for (int i = 0; i < 2060; i++) begin
      inflight = (occ == D-1) && (write_n === 1'b0);
      step();
      if (seen_ready !== exp_ready) ready_err++;
      if (inflight) begin
        seen_inflight++;
        total++; if (seen_ready !== '0) begin bad++; $display("FAIL fill_inflight_ready got=%b want=0", seen_ready); end
      end
    end
    total++; if (seen_inflight !== 1) begin bad++; $display("FAIL fill_inflight_seen got=%0d want=1", seen_inflight); end
    total++; if (ready_err !== 0) begin bad++; $display("FAIL fill_ready_errors got=%0d want=0", ready_err); end
    total++; if (writes !== D) begin bad++; $display("FAIL fill_writes got=%0d want=%0d", writes, D); end
    total++; if (bad_writes !== 0) begin bad++; $display("FAIL fill_write_while_full got=%0d want=0", bad_writes); end
    total++; if (write_n !== 1'b1) begin bad++; $display("FAIL fill_blocked_write_n got=%b want=1", write_n); end
    step(1'b1);
    repeat (4) step();
    total++; if (writes !== D + 1) begin bad++; $display("FAIL fill_resume_writes got=%0d want=%0d", writes, D + 1); end
    total++; if (occ !== D) begin bad++; $display("FAIL fill_resume_occ got=%0d want=%0d", occ, D); end
  endtask

  task automatic test_drop();
    logic [W-1:0] pkt;
    drop_on_full = 1'b1;
    req_valid = 4'b1010;
    repeat (10) step();
    total++; if (seen_ready !== 4'b1010) begin bad++; $display("FAIL drop_ready got=%b want=1010", seen_ready); end
    total++; if (int'(drop_count[1*DB +: DB]) !== 10) begin bad++; $display("FAIL drop_cnt1 got=%0d want=10", drop_count[1*DB +: DB]); end
    total++; if (int'(drop_count[3*DB +: DB]) !== 10) begin bad++; $display("FAIL drop_cnt3 got=%0d want=10", drop_count[3*DB +: DB]); end
    total++; if (int'(drop_count[0*DB +: DB]) !== 0) begin bad++; $display("FAIL drop_cnt0 got=%0d want=0", drop_count[0*DB +: DB]); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL drop_overflow got=%b want=1", overflow); end
    drop_on_full = 1'b0;
    pkt = rnd_word();
    pkt[60] = 1'b0;
    req_data[1*W +: W] = pkt;
    req_valid = 4'b0010;
    step(1'b1);
    step();
    req_valid = '0;
    total++; if (write_n !== 1'b0 || grant_id !== 2'd1) begin bad++; $display("FAIL drop_next_write got=%b/%0d want=0/1", write_n, grant_id); end
    total++; if (data_in[60] !== 1'b1) begin bad++; $display("FAIL drop_stamp_bit60 got=%b want=1", data_in[60]); end
    total++; if (data_in !== m_data) begin bad++; $display("FAIL drop_stamp_word got=%h want=%h", data_in, m_data); end
    clear_drop = 1'b1;
    step();
    clear_drop = 1'b0;
    total++; if (drop_count !== '0) begin bad++; $display("FAIL clear_counts got=%h want=0", drop_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clear_overflow got=%b want=0", overflow); end
    drop_on_full = 1'b1;
    req_valid = 4'b0010;
    clear_drop = 1'b1;
    step();
    clear_drop = 1'b0;
    req_valid = '0;
    total++; if (int'(drop_count[1*DB +: DB]) !== 1) begin bad++; $display("FAIL clear_vs_drop_cnt got=%0d want=1", drop_count[1*DB +: DB]); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clear_vs_drop_ovf got=%b want=1", overflow); end
    clear_drop = 1'b1;
    step();
    clear_drop = 1'b0;
  endtask

  task automatic test_saturation();
    drop_on_full = 1'b1;
    req_valid = 4'b0100;
    repeat (20) step();
    total++; if (int'(drop_count4[2*DB4 +: DB4]) !== 15) begin bad++; $display("FAIL sat_cnt4 got=%0d want=15", drop_count4[2*DB4 +: DB4]); end
    total++; if (int'(drop_count[2*DB +: DB]) !== 20) begin bad++; $display("FAIL sat_cnt16 got=%0d want=20", drop_count[2*DB +: DB]); end
    total++; if (overflow4 !== 1'b1) begin bad++; $display("FAIL sat_overflow got=%b want=1", overflow4); end
    req_valid = '0;
    clear_drop = 1'b1;
    step();
    clear_drop = 1'b0;
    drop_on_full = 1'b0;
  endtask

  task automatic test_random();
    writes = 0; bad_writes = 0;
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom);
      for (int j = 0; j < N; j++) req_data[j*W +: W] = rnd_word();
      priority_en  = ($urandom_range(0, 3) == 0);
      drop_on_full = ($urandom_range(0, 1) == 1);
      clear_drop   = ($urandom_range(0, 15) == 0);
      step(($urandom_range(0, 1) == 1));
      total++; if (seen_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready[%0d] got=%b want=%b", i, seen_ready, exp_ready); end
      total++; if (write_n !== m_wn) begin bad++; $display("FAIL rnd_write_n[%0d] got=%b want=%b", i, write_n, m_wn); end
      total++; if (data_in !== m_data) begin bad++; $display("FAIL rnd_data[%0d] got=%h want=%h", i, data_in, m_data); end
      total++; if (int'(grant_id) !== m_gid) begin bad++; $display("FAIL rnd_grant[%0d] got=%0d want=%0d", i, grant_id, m_gid); end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_overflow[%0d] got=%b want=%b", i, overflow, m_ovf); end
      for (int j = 0; j < N; j++) begin
        total++; if (int'(drop_count[j*DB +: DB]) !== m_drop[j]) begin bad++; $display("FAIL rnd_drop[%0d][%0d] got=%0d want=%0d", i, j, drop_count[j*DB +: DB], m_drop[j]); end
        total++; if (int'(drop_count4[j*DB4 +: DB4]) !== m_drop4[j]) begin bad++; $display("FAIL rnd_drop4[%0d][%0d] got=%0d want=%0d", i, j, drop_count4[j*DB4 +: DB4], m_drop4[j]); end
      end
    end
    total++; if (bad_writes !== 0) begin bad++; $display("FAIL rnd_write_while_full got=%0d want=0", bad_writes); end
    priority_en = 1'b0; drop_on_full = 1'b0; clear_drop = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    bit hit;
    hit = 1'b0;
    req_valid = '1;
    for (int i = 0; i < 10 && !hit; i++) begin
      step(1'b1);
      if (write_n === 1'b0) hit = 1'b1;
    end
    total++; if (!hit) begin bad++; $display("FAIL midrst_no_write got=write_n=1 want=a write within 10 cycles"); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (write_n !== 1'b1) begin bad++; $display("FAIL midrst_write_n got=%b want=1", write_n); end
    total++; if (data_in !== '0) begin bad++; $display("FAIL midrst_data_in got=%h want=0", data_in); end
    total++; if (req_ready !== '0) begin bad++; $display("FAIL midrst_req_ready got=%b want=0", req_ready); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_init();
    step();
    total++; if (grant_id !== 2'd0 || write_n !== 1'b0) begin bad++; $display("FAIL midrst_first_grant got=%0d/%b want=0/0", grant_id, write_n); end
    total++; if (data_in !== m_data) begin bad++; $display("FAIL midrst_first_data got=%h want=%h", data_in, m_data); end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1;
    req_valid = '0; req_data = '0;
    priority_en = 1'b0; drop_on_full = 1'b0; clear_drop = 1'b0;
    occ = 0; writes = 0; bad_writes = 0;
    set_fifo();
    model_init();
    test_reset();
    test_round_robin();
    test_priority();
    test_fill();
    test_drop();
    test_saturation();
    test_random();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
